// File: rtl/gate_stim_seq_pkg.sv
// rtl/gate_stim_seq_pkg.sv - shared types, sizes and truth-table helper for the gate stimulus sequencer
package gate_stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NUM_VECTORS = 4;
  localparam int RES_W       = 3;

  // Result bus layout of the gate stage: [2]=a&b, [1]=a|b, [0]=~a
  function automatic logic [RES_W-1:0] gate_expect(input logic a, input logic b);
    return {a & b, a | b, ~a};
  endfunction

endpackage

// File: rtl/gate_stim_seq_if.sv
// rtl/gate_stim_seq_if.sv - control/status and gate-stage bus of the sequencer
// GATE_STIM_LOOP_EN adds the stop request used by the looping variant.
interface gate_stim_seq_if;
  import gate_stim_pkg::*;

  logic                   start;
  logic [RES_W-1:0]       y_in;
  logic                   a;
  logic                   b;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [2:0]             err_count;
  logic [NUM_VECTORS-1:0] err_mask;
`ifdef GATE_STIM_LOOP_EN
  logic                   stop;

  modport master (input start, y_in, stop,
                  output a, b, busy, done, pass, err_count, err_mask);
  modport slave  (output start, y_in, stop,
                  input a, b, busy, done, pass, err_count, err_mask);
`else
  modport master (input start, y_in,
                  output a, b, busy, done, pass, err_count, err_mask);
  modport slave  (output start, y_in,
                  input a, b, busy, done, pass, err_count, err_mask);
`endif

endinterface

// File: rtl/gate_stim_seq_hold_timer.sv
// rtl/gate_stim_seq_hold_timer.sv - per-vector hold window counter; last marks the sampling edge
module gate_hold_timer #(
  parameter int HOLD_CYCLES = 50,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/gate_stim_seq.sv
// rtl/gate_stim_seq.sv - drives {a,b} through 00..11, checks gate results at end of each hold window
// GATE_STIM_LOOP_EN: repeat passes until stop is seen, accumulating errors.
module gate_stim_seq
  import gate_stim_pkg::*;
#(
  parameter int HOLD_CYCLES = 50,
  parameter int CNT_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  gate_stim_seq_if.master bus
);

  state_e                 state_q, state_d;
  logic [1:0]             vec_q, vec_d;
  logic                   a_q, a_d, b_q, b_d;
  logic                   busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [2:0]             err_count_q, err_count_d;
  logic [NUM_VECTORS-1:0] err_mask_q, err_mask_d;
  logic                   last;
  logic                   mismatch;
  logic                   finish;
`ifdef GATE_STIM_LOOP_EN
  logic                   stop_seen_q, stop_seen_d;
`endif

  gate_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q != RUN),
    .enable (state_q == RUN),
    .last   (last)
  );

  // Case-inequality so an X/Z result from the gate stage is a failure
  assign mismatch = (bus.y_in !== gate_expect(a_q, b_q));

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    a_d         = a_q;
    b_d         = b_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    err_mask_d  = err_mask_q;
    finish      = 1'b0;
`ifdef GATE_STIM_LOOP_EN
    stop_seen_d = stop_seen_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d     = RUN;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_count_d = '0;
          err_mask_d  = '0;
          vec_d       = '0;
          a_d         = 1'b0;
          b_d         = 1'b0;
`ifdef GATE_STIM_LOOP_EN
          stop_seen_d = 1'b0;
`endif
        end
      end
      RUN: begin
`ifdef GATE_STIM_LOOP_EN
        if (bus.stop) stop_seen_d = 1'b1;
`endif
        if (last) begin
          if (mismatch) begin
            err_mask_d[vec_q] = 1'b1;
            err_count_d       = (err_count_q == 3'd7) ? 3'd7 : err_count_q + 3'd1;
          end
          if (vec_q != 2'd3) begin
            vec_d      = vec_q + 2'd1;
            {a_d, b_d} = vec_q + 2'd1;
          end else begin
`ifdef GATE_STIM_LOOP_EN
            if (stop_seen_q || bus.stop) begin
              finish = 1'b1;
            end else begin
              vec_d      = '0;
              {a_d, b_d} = 2'b00;
            end
`else
            finish = 1'b1;
`endif
          end
          if (finish) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            a_d     = 1'b0;
            b_d     = 1'b0;
            pass_d  = (err_count_d == 3'd0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      err_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      err_mask_q  <= err_mask_d;
    end
  end

`ifdef GATE_STIM_LOOP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stop_seen_q <= 1'b0;
    else     stop_seen_q <= stop_seen_d;
  end
`endif

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_count_q;
  assign bus.err_mask  = err_mask_q;

endmodule

// File: tb/tb_gate_stim_seq.sv
// tb/tb_gate_stim_seq.sv - randomized self-checking bench for gate_stim_seq against a table-driven model
module tb_gate_stim_seq;

  localparam int H = 4;
  localparam logic [2:0] TRUTH [4] = '{3'b001, 3'b011, 3'b010, 3'b110};

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  // resp[k][p]: value the fake gate stage presents during cycle p of vector k's window
  logic [2:0] resp [4][H];

  gate_stim_seq_if ifc ();

  gate_stim_seq #(.HOLD_CYCLES(H), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] dut_status();
    return {ifc.done, ifc.busy, ifc.pass, ifc.err_count, ifc.err_mask};
  endfunction

  // Expected {done,busy,pass,err_count,err_mask} after npass passes of the current resp table
  function automatic logic [9:0] model_status(input int npass);
    logic [3:0] mask = '0;
    int         cnt = 0;
    for (int p = 0; p < npass; p++)
      for (int k = 0; k < 4; k++)
        if (resp[k][H-1] !== TRUTH[k]) begin
          mask[k] = 1'b1;
          cnt = (cnt < 7) ? cnt + 1 : 7;
        end
    return {1'b1, 1'b0, (cnt == 0), 3'(cnt), mask};
  endfunction

  task automatic fill_correct();
    for (int k = 0; k < 4; k++)
      for (int p = 0; p < H; p++) resp[k][p] = TRUTH[k];
  endtask

  task automatic drive_pass(input int pulse_at, input int rst_at);
    @(negedge clk); ifc.start = 1'b1;
    @(negedge clk); ifc.start = 1'b0;
    for (int c = 0; c < 4 * H; c++) begin
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        vectors++;
        if ({dut_status(), ifc.a, ifc.b} !== 12'd0) begin
          miscompares++;
          $display("FAIL reset_midpass: got %b want 0", {dut_status(), ifc.a, ifc.b});
        end
        @(negedge clk); rst = 1'b0;
        return;
      end
      vectors++;
      if ({ifc.a, ifc.b} !== 2'(c / H) || ifc.busy !== 1'b1 || ifc.done !== 1'b0) begin
        miscompares++;
        $display("FAIL run_cycle %0d: ab=%b busy=%b done=%b want ab=%b busy=1 done=0",
                 c, {ifc.a, ifc.b}, ifc.busy, ifc.done, 2'(c / H));
      end
      ifc.y_in  = resp[c / H][c % H];
      ifc.start = (c == pulse_at);
      @(negedge clk);
    end
    ifc.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ifc.start = 1'b0; ifc.y_in = '0;
`ifdef GATE_STIM_LOOP_EN
    ifc.stop = 1'b0;
`endif
    #1;
    vectors++;
    if ({dut_status(), ifc.a, ifc.b} !== 12'd0) begin
      miscompares++;
      $display("FAIL reset: got %b want 0", {dut_status(), ifc.a, ifc.b});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_correct();
    fill_correct();
    drive_pass(-1, -1);
    vectors++;
    if (dut_status() !== model_status(1)) begin
      miscompares++;
      $display("FAIL correct: got %b want %b", dut_status(), model_status(1));
    end
  endtask

  task automatic test_all_zero();
    for (int k = 0; k < 4; k++) for (int p = 0; p < H; p++) resp[k][p] = 3'b000;
    drive_pass(-1, -1);
    vectors++;
    if (dut_status() !== 10'b10_0_100_1111) begin
      miscompares++;
      $display("FAIL all_zero: got %b want %b", dut_status(), 10'b10_0_100_1111);
    end
  endtask

  task automatic test_stuck_y2();
    for (int k = 0; k < 4; k++) for (int p = 0; p < H; p++) resp[k][p] = TRUTH[k] & 3'b011;
    drive_pass(-1, -1);
    vectors++;
    if (dut_status() !== 10'b10_0_001_1000) begin
      miscompares++;
      $display("FAIL stuck_y2: got %b want %b", dut_status(), 10'b10_0_001_1000);
    end
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 4; k++)
      for (int p = 0; p < H; p++) resp[k][p] = (p == H - 1) ? TRUTH[k] : ~TRUTH[k];
    drive_pass(-1, -1);
    vectors++;
    if (dut_status() !== 10'b10_1_000_0000) begin
      miscompares++;
      $display("FAIL glitch: got %b want %b", dut_status(), 10'b10_1_000_0000);
    end
  endtask

  task automatic test_start_ignored();
    fill_correct();
    drive_pass(6, -1);
    vectors++;
    if (dut_status() !== model_status(1)) begin
      miscompares++;
      $display("FAIL start_ignored: got %b want %b", dut_status(), model_status(1));
    end
  endtask

  task automatic test_reset_midpass();
    fill_correct();
    drive_pass(-1, 7);
    resp[1][H-1] = 3'b111;
    drive_pass(-1, -1);
    vectors++;
    if (dut_status() !== model_status(1)) begin
      miscompares++;
      $display("FAIL after_reset_pass: got %b want %b", dut_status(), model_status(1));
    end
  endtask

  task automatic test_back_to_back();
    fill_correct();
    @(negedge clk); ifc.start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 4 * H; c++) begin
      ifc.y_in = resp[c / H][c % H];
      @(negedge clk);
    end
    vectors++;
    if (ifc.done !== 1'b1 || ifc.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_done: done=%b busy=%b want done=1 busy=0", ifc.done, ifc.busy);
    end
    @(negedge clk);
    vectors++;
    if (ifc.done !== 1'b0 || ifc.busy !== 1'b1 || {ifc.a, ifc.b} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_restart: done=%b busy=%b ab=%b want 0 1 00", ifc.done, ifc.busy, {ifc.a, ifc.b});
    end
    ifc.start = 1'b0;
    for (int c = 0; c < 4 * H; c++) begin
      ifc.y_in = resp[c / H][c % H];
      @(negedge clk);
    end
    vectors++;
    if (dut_status() !== model_status(1)) begin
      miscompares++;
      $display("FAIL b2b_second: got %b want %b", dut_status(), model_status(1));
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < 4; k++) begin
        for (int p = 0; p < H - 1; p++) resp[k][p] = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 5))
          0:       resp[k][H-1] = 3'($urandom_range(0, 7));
          1:       resp[k][H-1] = 3'bxx1;
          default: resp[k][H-1] = TRUTH[k];
        endcase
      end
      drive_pass(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1, -1);
      vectors++;
      if (dut_status() !== model_status(1)) begin
        miscompares++;
        $display("FAIL random_%0d: got %b want %b", it, dut_status(), model_status(1));
      end
    end
  endtask

`ifdef GATE_STIM_LOOP_EN
  task automatic test_loop();
    int cycles = 0;
    for (int k = 0; k < 4; k++) for (int p = 0; p < H; p++) resp[k][p] = TRUTH[k] | 3'b001;
    @(negedge clk); ifc.start = 1'b1;
    @(negedge clk); ifc.start = 1'b0;
    while (ifc.done !== 1'b1 && cycles < 64) begin
      ifc.stop = (cycles == 20);
      ifc.y_in = resp[{ifc.a, ifc.b}][0];
      @(negedge clk);
      cycles++;
    end
    ifc.stop = 1'b0;
    vectors++;
    if (cycles != 32 || dut_status() !== model_status(2)) begin
      miscompares++;
      $display("FAIL loop_stop: cycles=%0d status=%b want cycles=32 status=%b",
               cycles, dut_status(), model_status(2));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_correct();
    test_all_zero();
    test_stuck_y2();
    test_glitch();
    test_start_ignored();
    test_reset_midpass();
    test_back_to_back();
    test_random();
`ifdef GATE_STIM_LOOP_EN
    test_loop();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gate_stim_seq.md
Name: gate_stim_seq

Overview:
- Upstream stimulus/response sequencer for the two-input gates stage (outputs AND, OR, NOT-a on a 3-bit bus).
- Drives operands a/b through all four combinations, holding each for a programmable number of cycles.
- Samples the gate stage's 3-bit result at the end of each hold window and compares it against the expected truth table.
- Reports per-vector errors, an error count and a pass flag. Used as the self-checking front end for lab gate experiments on hardware.

Parameters:
HOLD_CYCLES, 50, cycles each operand vector is held; legal range 2..65535
CNT_W, 16, width of hold counter; must satisfy 2**CNT_W > HOLD_CYCLES

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-high
start  in  1  request a test pass; sampled only in IDLE or DONE
y_in  in  3  result from gate stage: [2]=a&b, [1]=a|b, [0]=~a
a  out  1  operand a to gate stage (registered)
b  out  1  operand b to gate stage (registered)
busy  out  1  high while vectors are being driven
done  out  1  level; high from end of a pass until next start
pass  out  1  valid while done; 1 when err_count==0
err_count  out  3  number of mismatching vectors in last pass (0..4)
err_mask  out  4  bit k set when vector k ({a,b}=k) mismatched

Behaviour:
- Reset (async, any state): state=IDLE; a=0, b=0, busy=0, done=0, pass=0, err_count=0, err_mask=0, vec=0, hold counter=0. Takes effect immediately, including mid-pass. No partial results are retained.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE/DONE, start=1 at edge:
  - next state RUN; busy=1, done=0, pass=0.
  - err_count=0, err_mask=0, vec=0, counter=0.
  - {a,b}=2'b00.
- RUN, each edge:
  - If counter<HOLD_CYCLES-1: counter+1.
  - If counter==HOLD_CYCLES-1: compare y_in against exp={a&b, a|b, ~a}, using current registered a/b. On mismatch, set err_mask[vec] and increment err_count.
  - After the compare: if vec<3, then vec+1, {a,b}=vec+1, counter=0. If vec==3, go to DONE.
- Vector order: 00, 01, 10, 11 with {a,b}=vec (a=vec[1], b=vec[0]).
- Timing:
  - Each vector is driven for exactly HOLD_CYCLES cycles.
  - y_in is sampled on the last edge of the window, giving HOLD_CYCLES-1 cycles of settle.
  - busy is high for exactly 4*HOLD_CYCLES cycles.
- Entering DONE: busy=0, done=1, {a,b}=00. pass=1 iff no mismatch occurred, including one from the final vector's compare on the same edge.
- start while RUN: ignored. No queuing.
- start held high continuously: a new pass starts on the first edge in DONE, so done is high for one cycle.
- X/Z on y_in counts as mismatch (strict compare).

Optional Feature:
GATE_STIM_LOOP_EN
- Defined:
  - Adds input port stop (1 bit).
  - After vector 3, wraps to vector 0 and continues RUN instead of entering DONE.
  - err_mask accumulates stickily; err_count saturates at 7.
  - When stop is seen high in any RUN cycle, the current pass completes through vector 3 and the block then enters DONE.
  - pass reflects all passes since start.
- Undefined: no stop port; single pass as described above.

Decomposition:
- Package gate_stim_pkg:
  - state enum {IDLE, RUN, DONE}
  - NUM_VECTORS=4, RES_W=3
  - function gate_expect(a,b) returning the 3-bit expected result
- Sub-module gate_hold_timer (parameter HOLD_CYCLES, CNT_W):
  - inputs: clear, enable
  - output: last, high when counter==HOLD_CYCLES-1
  - The sequencer FSM instantiates it once.

Test Plan:
- HOLD_CYCLES=4, y_in driven by correct gate model, one start pulse:
  - busy rises next edge; {a,b}=00,01,10,11 for 4 cycles each.
  - done=1 after 16 busy cycles; pass=1, err_count=0, err_mask=0000.
- y_in forced 3'b000 (expected 001, 011, 010, 110) -> err_count=4, err_mask=1111, pass=0.
- y_in[2] stuck 0, others correct -> err_mask=1000, err_count=1, pass=0.
- Glitch on y_in only in the first 3 cycles of each window, correct on the 4th -> pass=1, verifying the last-cycle sampling point.
- start pulsed again during RUN at cycle 6 -> ignored, done at 16. Then assert rst at cycle 7 of a new pass -> all outputs 0 immediately; next start runs a clean full pass.
- With GATE_STIM_LOOP_EN: y_in[0] stuck 1, stop asserted at cycle 20 -> runs 2 passes (32 cycles), err_mask=1100, err_count=4, done=1.
